mux_n_pipe: RTL and testbench
=============================

Name: mux_n_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered, flow-controlled output.
- Generalises the team's fixed 2-way 64-bit and 5-bit selectors to any width and channel count.
- Adds a valid/ready handshake and a 2-entry skid buffer, so it can sit between pipeline stages (e.g. the forwarding or writeback select) without a combinational ready path.
- Flags select codes outside the valid channel range.

Parameters:
- WIDTH, 64, data width of each channel and of the output.
- NUM_IN, 4, number of input channels; must be 2 or more.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  channel select, sampled with in_data.
- in_valid  input  1  upstream offers in_data/in_sel.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  select code that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts this cycle.
- sel_err  output  1  sticky; set by any accepted out-of-range select.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While reset is high, at the next rising edge:
  - out_valid=0, out_data=0, out_sel=0, sel_err=0;
  - skid entry cleared;
  - state=EMPTY.
- in_ready is forced 0 while reset is high. Inputs presented during reset are ignored.
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Capture: on input transfer the block stores {word, sel}.
  - word = channel in_sel when in_sel < NUM_IN.
  - word = all zeros otherwise, and sel_err is set to 1. sel_err holds until reset.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N when the main register is empty or drains at edge N. Minimum latency is 1 cycle.
- Storage: main register (drives the outputs) and skid register. State encoding is EMPTY, ONE, FULL.
- in_ready = (state != FULL). It is a function of state only, never of out_ready.
- Transitions (in = input transfer, out = output transfer):
  - EMPTY, in -> ONE; main <= captured.
  - ONE, in and out -> ONE; main <= captured.
  - ONE, in only -> FULL; skid <= captured.
  - ONE, out only -> EMPTY.
  - FULL, out -> ONE; main <= skid. No input is possible in FULL.
  - Any other combination -> hold.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sel do not change.
- When out_valid=0, out_data/out_sel hold their last value (0 after reset).
- Ordering: words leave strictly in acceptance order. No drop, no duplication.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Reset mid-operation: any words in main/skid are discarded. Outputs return to their reset values at the reset edge.
- No combinational path from any input to any output except the reset gating of in_ready.

Test Plan:
- Reset then pass-through (NUM_IN=4, WIDTH=64): ch0..3 = 0x1111..., 0x2222..., 0x3333..., 0x4444...; sel=2, in_valid=1 for 1 cycle, out_ready=1 -> out_data=0x3333..., out_sel=2, out_valid=1 for exactly 1 cycle, one cycle after acceptance.
- Streaming: sel sequence 0,1,2,3 on consecutive cycles with out_ready=1 -> outputs 0x1111...,0x2222...,0x3333...,0x4444... on 4 consecutive cycles; in_ready stays 1.
- Back-pressure: out_ready=0 while sending sel=1 then sel=3 -> after 2 accepts in_ready=0 (FULL) and out_data holds 0x2222...; raise out_ready -> 0x2222... then 0x4444..., in_ready returns to 1.
- Out-of-range (NUM_IN=3, SEL_W=2): sel=3 accepted -> out_data=0, out_sel=3, sel_err=1; a subsequent sel=0 outputs channel 0 while sel_err stays 1 until reset.
- Reset mid-operation: FULL with out_ready=0, assert reset 1 cycle -> out_valid=0, out_data=0, sel_err=0, in_ready=1 the cycle after reset deasserts; the discarded words never appear.
- Parameter sweep: WIDTH=5, NUM_IN=2, SEL_W=1; ch0=5'h0A, ch1=5'h15; sel=1 -> out_data=5'h15 with 1-cycle latency.

Source files
------------

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input, WIDTH-bit selector feeding a registered output stage
// with a valid/ready handshake and a 2-entry (main + skid) buffer.
//
// Handshake: a word moves across an interface at a rising clk edge only when
// its valid and ready are both 1 there. Once valid is raised it stays up, and
// the payload stays stable, until that transfer happens. in_ready depends only
// on the buffer state (and on reset), never on out_ready.
module mux_n_pipe #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  // EMPTY: nothing held; ONE: main holds a word; FULL: main and skid both hold one.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic               sel_err_q, sel_err_d;

  logic [WIDTH-1:0]   cap_data;
  logic               cap_err;
  logic               in_xfer;
  logic               out_xfer;

  // Channel select: out-of-range codes produce an all-zero word and an error flag.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  // Reset gates in_ready so nothing is accepted while the buffer is being cleared.
  assign in_ready  = !reset && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign sel_err   = sel_err_q;

  // Next-state and buffer steering; every register holds unless a transfer moves it.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    sel_err_d   = sel_err_q | (in_xfer & cap_err);
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_data_d = cap_data;
          main_sel_d  = in_sel;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_data_d = cap_data;
          main_sel_d  = in_sel;
        end else if (in_xfer) begin
          skid_data_d = cap_data;
          skid_sel_d  = in_sel;
          state_d     = FULL;
        end else if (out_xfer) begin
          state_d     = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      sel_err_q   <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: three instances cover the 4x64 default,
// a 3-channel build with an unused select code, and a 2x5 build.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] ch_val [4];
  logic [63:0] exp_q [$];

  // ---------------- instance a: WIDTH=64, NUM_IN=4, SEL_W=2
  logic         a_reset;
  logic [255:0] a_in_data;
  logic [1:0]   a_in_sel;
  logic         a_in_valid, a_in_ready;
  logic [63:0]  a_out_data;
  logic [1:0]   a_out_sel;
  logic         a_out_valid, a_out_ready, a_sel_err;

  mux_n_pipe #(.WIDTH(64), .NUM_IN(4), .SEL_W(2)) u_a (
    .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sel_err(a_sel_err)
  );

  // ---------------- instance b: WIDTH=64, NUM_IN=3, SEL_W=2
  logic         b_reset;
  logic [191:0] b_in_data;
  logic [1:0]   b_in_sel;
  logic         b_in_valid, b_in_ready;
  logic [63:0]  b_out_data;
  logic [1:0]   b_out_sel;
  logic         b_out_valid, b_out_ready, b_sel_err;

  mux_n_pipe #(.WIDTH(64), .NUM_IN(3), .SEL_W(2)) u_b (
    .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sel_err(b_sel_err)
  );

  // ---------------- instance c: WIDTH=5, NUM_IN=2, SEL_W=1
  logic         c_reset;
  logic [9:0]   c_in_data;
  logic [0:0]   c_in_sel;
  logic         c_in_valid, c_in_ready;
  logic [4:0]   c_out_data;
  logic [0:0]   c_out_sel;
  logic         c_out_valid, c_out_ready, c_sel_err;

  mux_n_pipe #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) u_c (
    .clk(clk), .reset(c_reset), .in_data(c_in_data), .in_sel(c_in_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .sel_err(c_sel_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_sel = 1'b1; c_out_ready = 1'b0;
    tick();
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", a_out_valid); end
    total++; if (a_out_data !== 64'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", a_out_data); end
    total++; if (a_out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel got=%0d want=0", a_out_sel); end
    total++; if (a_sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%0b want=0", a_sel_err); end
    tick();
    // inputs offered during reset must have been ignored, including b's bad select
    total++; if (b_sel_err !== 1'b0 || b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_b_ignored err=%0b valid=%0b want=0,0", b_sel_err, b_out_valid); end
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b want=1", a_in_ready); end
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%0b want=0", a_out_valid); end
  endtask

  task automatic test_pass_through();
    a_in_sel = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%0b want=1", a_out_valid); end
    total++; if (a_out_data !== 64'h3333_3333_3333_3333) begin bad++; $display("FAIL pass_data got=%h want=3333333333333333", a_out_data); end
    total++; if (a_out_sel !== 2'd2) begin bad++; $display("FAIL pass_sel got=%0d want=2", a_out_sel); end
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL pass_one_cycle got=%0b want=0", a_out_valid); end
    total++; if (a_out_data !== 64'h3333_3333_3333_3333) begin bad++; $display("FAIL pass_hold got=%h want=3333333333333333", a_out_data); end
  endtask

  task automatic test_streaming();
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_sel = 2'(i); a_in_valid = 1'b1;
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%0b want=1", i, a_in_ready); end
      tick();
      total++; if (a_out_valid !== 1'b1 || a_out_data !== ch_val[i]) begin bad++; $display("FAIL stream_out[%0d] valid=%0b data=%h want=1,%h", i, a_out_valid, a_out_data, ch_val[i]); end
    end
    a_in_valid = 1'b0;
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b want=0", a_out_valid); end
  endtask

  task automatic test_back_pressure();
    a_out_ready = 1'b0;
    a_in_sel = 2'd1; a_in_valid = 1'b1;
    tick();
    total++; if (a_in_ready !== 1'b1 || a_out_data !== 64'h2222_2222_2222_2222) begin bad++; $display("FAIL bp_one ready=%0b data=%h want=1,2222222222222222", a_in_ready, a_out_data); end
    a_in_sel = 2'd3;
    tick();
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b want=0", a_in_ready); end
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h2222_2222_2222_2222) begin bad++; $display("FAIL bp_full_data valid=%0b data=%h want=1,2222222222222222", a_out_valid, a_out_data); end
    // a word offered while FULL must not be taken
    a_in_sel = 2'd0;
    tick();
    total++; if (a_out_data !== 64'h2222_2222_2222_2222 || a_out_sel !== 2'd1) begin bad++; $display("FAIL bp_stable data=%h sel=%0d want=2222222222222222,1", a_out_data, a_out_sel); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    total++; if (a_out_data !== 64'h4444_4444_4444_4444 || a_out_sel !== 2'd3) begin bad++; $display("FAIL bp_skid data=%h sel=%0d want=4444444444444444,3", a_out_data, a_out_sel); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0b want=1", a_in_ready); end
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_extra got=%0b want=0", a_out_valid); end
  endtask

  task automatic test_out_of_range();
    b_out_ready = 1'b1;
    b_in_sel = 2'd2; b_in_valid = 1'b1;
    tick();
    total++; if (b_out_data !== 64'h3333_3333_3333_3333 || b_sel_err !== 1'b0) begin bad++; $display("FAIL oor_last_ok data=%h err=%0b want=3333333333333333,0", b_out_data, b_sel_err); end
    b_in_sel = 2'd3;
    tick();
    total++; if (b_out_data !== 64'd0 || b_out_sel !== 2'd3) begin bad++; $display("FAIL oor_word data=%h sel=%0d want=0,3", b_out_data, b_out_sel); end
    total++; if (b_sel_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%0b want=1", b_sel_err); end
    b_in_sel = 2'd0;
    tick();
    b_in_valid = 1'b0;
    total++; if (b_out_data !== 64'h1111_1111_1111_1111 || b_sel_err !== 1'b1) begin bad++; $display("FAIL oor_sticky data=%h err=%0b want=1111111111111111,1", b_out_data, b_sel_err); end
    tick();
    total++; if (b_sel_err !== 1'b1 || b_out_valid !== 1'b0) begin bad++; $display("FAIL oor_hold err=%0b valid=%0b want=1,0", b_sel_err, b_out_valid); end
  endtask

  task automatic test_reset_mid();
    b_out_ready = 1'b0;
    b_in_sel = 2'd1; b_in_valid = 1'b1;
    tick();
    b_in_sel = 2'd2;
    tick();
    b_in_valid = 1'b0;
    total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%0b want=0", b_in_ready); end
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    total++; if (b_out_valid !== 1'b0 || b_out_data !== 64'd0 || b_out_sel !== 2'd0 || b_sel_err !== 1'b0) begin bad++; $display("FAIL mid_reset valid=%0b data=%h sel=%0d err=%0b want=0,0,0,0", b_out_valid, b_out_data, b_out_sel, b_sel_err); end
    #1;
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b want=1", b_in_ready); end
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL mid_discard[%0d] valid=%0b data=%h want=0", i, b_out_valid, b_out_data); end
    end
    b_in_sel = 2'd0; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    total++; if (b_out_valid !== 1'b1 || b_out_data !== 64'h1111_1111_1111_1111) begin bad++; $display("FAIL mid_restart valid=%0b data=%h want=1,1111111111111111", b_out_valid, b_out_data); end
  endtask

  task automatic test_param_sweep();
    c_out_ready = 1'b1;
    c_in_sel = 1'b1; c_in_valid = 1'b1;
    tick();
    total++; if (c_out_valid !== 1'b1 || c_out_data !== 5'h15 || c_out_sel !== 1'b1) begin bad++; $display("FAIL sweep_ch1 valid=%0b data=%h sel=%0d want=1,15,1", c_out_valid, c_out_data, c_out_sel); end
    c_in_sel = 1'b0;
    tick();
    c_in_valid = 1'b0;
    total++; if (c_out_data !== 5'h0A || c_out_sel !== 1'b0) begin bad++; $display("FAIL sweep_ch0 data=%h sel=%0d want=0a,0", c_out_data, c_out_sel); end
    tick();
    total++; if (c_out_valid !== 1'b0 || c_sel_err !== 1'b0) begin bad++; $display("FAIL sweep_idle valid=%0b err=%0b want=0,0", c_out_valid, c_sel_err); end
  endtask

  // mixed back-pressure with a fixed out_ready pattern; order checked via exp_q
  task automatic test_back_to_back();
    logic [7:0] pat;
    int sent;
    int cyc;
    logic [63:0] exp_w;
    pat  = 8'b1011_0110;
    sent = 0;
    cyc  = 0;
    exp_q.delete();
    while (cyc < 100 && (sent < 12 || exp_q.size() > 0)) begin
      a_in_valid  = (sent < 12);
      a_in_sel    = 2'(sent % 4);
      a_out_ready = pat[cyc % 8];
      #1;
      if (a_out_valid && a_out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra data=%h want=none", a_out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (a_out_data !== exp_w) begin bad++; $display("FAIL b2b_order data=%h want=%h", a_out_data, exp_w); end
        end
      end
      if (a_in_valid && a_in_ready) begin
        exp_q.push_back(ch_val[sent % 4]);
        sent++;
      end
      tick();
      cyc++;
    end
    a_in_valid = 1'b0;
    total++; if (sent != 12 || exp_q.size() != 0) begin bad++; $display("FAIL b2b_timeout sent=%0d pending=%0d want=12,0", sent, exp_q.size()); end
  endtask

  initial begin
    ch_val[0] = 64'h1111_1111_1111_1111;
    ch_val[1] = 64'h2222_2222_2222_2222;
    ch_val[2] = 64'h3333_3333_3333_3333;
    ch_val[3] = 64'h4444_4444_4444_4444;
    a_in_data = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};
    b_in_data = {ch_val[2], ch_val[1], ch_val[0]};
    c_in_data = {5'h15, 5'h0A};
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_in_sel = '0; b_in_sel = '0; c_in_sel = '0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
    #1;
    test_reset();
    test_pass_through();
    test_streaming();
    test_back_pressure();
    test_out_of_range();
    test_reset_mid();
    test_param_sweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
